// File: rtl/d_sc_syndrome_collector_pkg.sv
// Shared definitions for the syndrome collector: one-hot states, default sizes
// and the bit offset of (syndrome s, chunk k) inside the packed output block.
package d_sc_syndrome_collector_pkg;

  localparam int GF_DEF        = 12;
  localparam int SYNDROMES_DEF = 27;
  localparam int MULTI_DEF     = 2;

  typedef enum logic [2:0] {
    COLLECT = 3'b001,
    FULL    = 3'b010,
    ISSUE   = 3'b100
  } state_t;

  // Syndrome s (1-based, S1 in MSBs) owns a Multi*GF slice; chunk k sits GF*k above its LSB.
  function automatic int pack_offset(input int s, input int k, input int multi,
                                     input int gf, input int syn);
    return multi * gf * (syn - s) + gf * k;
  endfunction

endpackage

// File: rtl/d_sc_syndrome_collector_zero_detect.sv
// Nonzero detector for one chunk's syndrome vector; kept separate so it can be pipelined.
module d_sc_syndrome_collector_zero_detect #(
  parameter int W = 324
) (
  input  logic [W-1:0] data,
  output logic         nonzero
);

  assign nonzero = |data;

endmodule

// File: rtl/d_sc_syndrome_collector.sv
// Collects MULTI chunk syndrome vectors into one interleaved block and issues it to the KES buffer.
// Optional macro SC_COLLECT_STATS_EN adds saturating block / dirty-block counters.
module d_sc_syndrome_collector
  import d_sc_syndrome_collector_pkg::*;
#(
  parameter int MULTI     = MULTI_DEF,
  parameter int GF        = GF_DEF,
  parameter int SYNDROMES = SYNDROMES_DEF
) (
  input  logic                              i_clk,
  input  logic                              i_RESET,
  input  logic                              i_stop_dec,
  input  logic                              i_sc_valid,
  input  logic [GF*SYNDROMES-1:0]           i_sc_syndromes,
  output logic                              o_sc_ready,
  input  logic                              i_buf_available,
  output logic                              o_exe_buf,
  output logic [MULTI-1:0]                  o_ELP_search_needed,
  output logic [MULTI*GF*SYNDROMES-1:0]     o_syndromes,
  output logic                              o_block_clean
`ifdef SC_COLLECT_STATS_EN
  ,
  output logic [15:0]                       o_stat_blocks,
  output logic [15:0]                       o_stat_dirty_blocks
`endif
);

  localparam int CW = (MULTI > 1) ? $clog2(MULTI) : 1;
  localparam int BW = MULTI * GF * SYNDROMES;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          syn_p1, syn_next;
  logic [MULTI-1:0]       flags_p1, flags_next;
  logic                   exe_p1;
  logic                   clean_p1;
  logic                   chunk_nonzero;
  logic                   last_chunk;

  d_sc_syndrome_collector_zero_detect #(.W(GF*SYNDROMES)) u_zero_detect (
    .data    (i_sc_syndromes),
    .nonzero (chunk_nonzero)
  );

  assign last_chunk = (cnt == CW'(MULTI - 1));

  // Chunk 0 starts from a cleared block so nothing from the previous block survives.
  always_comb begin
    syn_next   = (cnt == '0) ? '0 : syn_p1;
    flags_next = (cnt == '0) ? '0 : flags_p1;
    for (int s = 1; s <= SYNDROMES; s++) begin
      syn_next[pack_offset(s, int'(cnt), MULTI, GF, SYNDROMES) +: GF] =
        i_sc_syndromes[GF*(SYNDROMES-s) +: GF];
    end
    flags_next[cnt] = chunk_nonzero;
  end

  always_ff @(posedge i_clk) begin
    if (i_RESET || i_stop_dec) begin
      state    <= COLLECT;
      cnt      <= '0;
      exe_p1   <= 1'b0;
      clean_p1 <= 1'b0;
      flags_p1 <= '0;
      syn_p1   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (i_sc_valid) begin
            syn_p1   <= syn_next;
            flags_p1 <= flags_next;
            if (last_chunk) begin
              state <= FULL;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FULL: begin
          if (i_buf_available) begin
            state    <= ISSUE;
            exe_p1   <= 1'b1;
            clean_p1 <= ~|flags_p1;
          end
        end
        ISSUE: begin
          state    <= COLLECT;
          exe_p1   <= 1'b0;
          clean_p1 <= 1'b0;
        end
        default: begin
          state    <= COLLECT;
          cnt      <= '0;
          exe_p1   <= 1'b0;
          clean_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign o_sc_ready          = (state == COLLECT);
  assign o_exe_buf           = exe_p1;
  assign o_ELP_search_needed = flags_p1;
  assign o_syndromes         = syn_p1;
  assign o_block_clean       = clean_p1;

`ifdef SC_COLLECT_STATS_EN
  // Statistics survive an abort; only a full reset clears them.
  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      o_stat_blocks       <= '0;
      o_stat_dirty_blocks <= '0;
    end else if (state == ISSUE) begin
      if (o_stat_blocks != 16'hFFFF)
        o_stat_blocks <= o_stat_blocks + 16'd1;
      if (!clean_p1 && o_stat_dirty_blocks != 16'hFFFF)
        o_stat_dirty_blocks <= o_stat_dirty_blocks + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_d_sc_syndrome_collector.sv
// Directed bench for d_sc_syndrome_collector at MULTI=2, GF=12, SYNDROMES=27.
module tb_d_sc_syndrome_collector;

  localparam int MULTI = 2;
  localparam int GF    = 12;
  localparam int SYN   = 27;
  localparam int IW    = GF * SYN;
  localparam int BW    = MULTI * GF * SYN;

  logic              clk = 1'b0;
  logic              rst;
  logic              stop_dec;
  logic              sc_valid;
  logic [IW-1:0]     sc_syndromes;
  logic              sc_ready;
  logic              buf_available;
  logic              exe_buf;
  logic [MULTI-1:0]  elp_needed;
  logic [BW-1:0]     syndromes;
  logic              block_clean;
`ifdef SC_COLLECT_STATS_EN
  logic [15:0]       stat_blocks;
  logic [15:0]       stat_dirty_blocks;
`endif

  int nchecks = 0;
  int nerrors = 0;

  logic [BW-1:0] exp_blk;
  logic [23:0]   top24;

  always #5 clk = ~clk;

  d_sc_syndrome_collector #(.MULTI(MULTI), .GF(GF), .SYNDROMES(SYN)) dut (
    .i_clk               (clk),
    .i_RESET             (rst),
    .i_stop_dec          (stop_dec),
    .i_sc_valid          (sc_valid),
    .i_sc_syndromes      (sc_syndromes),
    .o_sc_ready          (sc_ready),
    .i_buf_available     (buf_available),
    .o_exe_buf           (exe_buf),
    .o_ELP_search_needed (elp_needed),
    .o_syndromes         (syndromes),
    .o_block_clean       (block_clean)
`ifdef SC_COLLECT_STATS_EN
    ,
    .o_stat_blocks       (stat_blocks),
    .o_stat_dirty_blocks (stat_dirty_blocks)
`endif
  );

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    stop_dec      = 1'b0;
    sc_valid      = 1'b1;
    sc_syndromes  = '1;
    buf_available = 1'b1;
    tick();
    tick();
    chk("rst_exe",   BW'(exe_buf), '0);
    chk("rst_flags", BW'(elp_needed), '0);
    chk("rst_syn",   syndromes, '0);
    chk("rst_clean", BW'(block_clean), '0);
    chk("rst_ready", BW'(sc_ready), BW'(1));
    sc_valid = 1'b0;
    rst      = 1'b0;
    tick();
    chk("idle_syn", syndromes, '0);

    // Block A: chunk0 S1=0x001, chunk1 zero
    sc_valid     = 1'b1;
    sc_syndromes = '0;
    sc_syndromes[IW-1 -: GF] = 12'h001;
    tick();
    chk("a_ready_mid", BW'(sc_ready), BW'(1));
    sc_syndromes = '0;
    tick();
    sc_valid = 1'b0;
    chk("a_ready_full", BW'(sc_ready), '0);
    chk("a_exe_full",   BW'(exe_buf), '0);
    tick();
    top24 = syndromes[BW-1 -: 24];
    exp_blk = '0;
    exp_blk[BW-24] = 1'b1;
    chk("a_exe",   BW'(exe_buf), BW'(1));
    chk("a_flags", BW'(elp_needed), BW'(2'b01));
    chk("a_clean", BW'(block_clean), '0);
    chk("a_top24", BW'(top24), BW'(24'h000001));
    chk("a_syn",   syndromes, exp_blk);
    tick();
    chk("a_exe_off",  BW'(exe_buf), '0);
    chk("a_ready_bk", BW'(sc_ready), BW'(1));
    chk("a_hold",     syndromes, exp_blk);

    // Block B: two all-zero chunks
    sc_valid     = 1'b1;
    sc_syndromes = '0;
    tick();
    tick();
    sc_valid = 1'b0;
    chk("b_ready_full", BW'(sc_ready), '0);
    tick();
    chk("b_exe",   BW'(exe_buf), BW'(1));
    chk("b_flags", BW'(elp_needed), '0);
    chk("b_clean", BW'(block_clean), BW'(1));
    chk("b_syn",   syndromes, '0);
    tick();

    // Block C: chunk0 S27=0x123, chunk1 S2=0x456, buffer busy for 10 cycles
    buf_available = 1'b0;
    sc_valid      = 1'b1;
    sc_syndromes  = '0;
    sc_syndromes[GF-1:0] = 12'h123;
    tick();
    sc_syndromes = '0;
    sc_syndromes[GF*(SYN-2) +: GF] = 12'h456;
    tick();
    sc_valid = 1'b1;
    sc_syndromes = '1;
    exp_blk = '0;
    exp_blk[11:0] = 12'h123;
    exp_blk[612 +: 12] = 12'h456;
    for (int i = 0; i < 10; i++) begin
      chk("c_wait_ready", BW'(sc_ready), '0);
      chk("c_wait_exe",   BW'(exe_buf), '0);
      chk("c_wait_syn",   syndromes, exp_blk);
      tick();
    end
    sc_valid      = 1'b0;
    buf_available = 1'b1;
    tick();
    chk("c_exe",   BW'(exe_buf), BW'(1));
    chk("c_flags", BW'(elp_needed), BW'(2'b11));
    chk("c_clean", BW'(block_clean), '0);
    chk("c_syn",   syndromes, exp_blk);
    tick();
    chk("c_exe_off", BW'(exe_buf), '0);

    // Block D: chunk0 S27=0xABC then abort; next two zero chunks form the block
    sc_valid     = 1'b1;
    sc_syndromes = '0;
    sc_syndromes[GF-1:0] = 12'hABC;
    tick();
    sc_valid = 1'b0;
    stop_dec = 1'b1;
    tick();
    stop_dec = 1'b0;
    chk("d_stop_syn",   syndromes, '0);
    chk("d_stop_ready", BW'(sc_ready), BW'(1));
    sc_valid     = 1'b1;
    sc_syndromes = '0;
    tick();
    chk("d_ready_mid", BW'(sc_ready), BW'(1));
    tick();
    sc_valid = 1'b0;
    chk("d_ready_full", BW'(sc_ready), '0);
    tick();
    chk("d_exe",   BW'(exe_buf), BW'(1));
    chk("d_syn",   syndromes, '0);
    chk("d_flags", BW'(elp_needed), '0);
    chk("d_clean", BW'(block_clean), BW'(1));
    tick();

`ifdef SC_COLLECT_STATS_EN
    chk("st_blocks", BW'(stat_blocks), BW'(4));
    chk("st_dirty",  BW'(stat_dirty_blocks), BW'(2));
    stop_dec = 1'b1;
    tick();
    stop_dec = 1'b0;
    chk("st_blocks_stop", BW'(stat_blocks), BW'(4));
    chk("st_dirty_stop",  BW'(stat_dirty_blocks), BW'(2));
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/d_sc_syndrome_collector.md
Name: d_SC_syndrome_collector

Overview:
- Upstream neighbour of the syndrome-to-KES buffer.
- Accepts per-chunk syndrome vectors from the syndrome calculator one chunk at a time and packs Multi chunks into the interleaved bus the buffer consumes.
- Derives a per-chunk "ELP search needed" flag (any syndrome nonzero) and issues a one-cycle execute pulse when the buffer reports available.

Parameters:
- Multi, 2, chunks per issued block (1..8).
- GF, 12, Galois-field symbol width in bits.
- Syndromes, 27, syndromes per chunk.

Ports:
- i_clk  in  1  clock
- i_RESET  in  1  synchronous active-high reset
- i_stop_dec  in  1  synchronous abort; same effect as reset
- i_sc_valid  in  1  chunk syndrome vector valid
- i_sc_syndromes  in  GF*Syndromes  chunk syndromes; S1 in MSBs, S_s at [GF*(Syndromes-s+1)-1 : GF*(Syndromes-s)]
- o_sc_ready  out  1  collector can accept a chunk
- i_buf_available  in  1  downstream buffer idle
- o_exe_buf  out  1  one-cycle issue pulse
- o_ELP_search_needed  out  Multi  bit k = chunk k has a nonzero syndrome
- o_syndromes  out  Multi*GF*Syndromes  packed block; valid while o_exe_buf=1
- o_block_clean  out  1  o_ELP_search_needed==0; qualified by o_exe_buf

Behaviour:
- Reset and i_stop_dec are synchronous and act identically:
  - state goes to COLLECT, chunk counter to 0
  - o_exe_buf, o_ELP_search_needed, o_syndromes, o_block_clean all go to 0
  - o_sc_ready is 1 in the first cycle after reset
- A partially collected block is discarded on reset or abort.
- Accept occurs when i_sc_valid && o_sc_ready.
- o_sc_ready is 1 only in state COLLECT (decoded combinationally from state).
- Packing on accepting chunk k (k = counter value):
  - the slice for syndrome s is [Multi*GF*(Syndromes-s+1)-1 : Multi*GF*(Syndromes-s)]
  - within that slice, chunk k occupies bits [GF*(k+1)-1 : GF*k]
  - chunk 0 sits in the LSBs, so the downstream right-shift by GF yields the next chunk
- On accepting chunk k, flag bit k = OR-reduce of i_sc_syndromes, registered.
- On accepting chunk 0, all other flag bits and syndrome fields are cleared in the same edge, so no stale data survives.
- Counter increments on each accept. The accept with counter==Multi-1 moves the state to FULL and resets the counter to 0.
- States (one-hot):
  - COLLECT: accepts chunks as above.
  - FULL: waits for i_buf_available.
    - FULL with i_buf_available=1 goes to ISSUE.
    - FULL with i_buf_available=0 stays in FULL; nothing else changes.
  - ISSUE: o_exe_buf=1 for exactly one cycle, then COLLECT.
- o_exe_buf is registered (asserted while the current state is ISSUE). o_block_clean is also valid during ISSUE.
- Latency:
  - last-chunk accept at edge N puts the state in FULL for cycle N+1
  - with i_buf_available=1 in cycle N+1, o_exe_buf is high in cycle N+2
  - the earliest next chunk accept is cycle N+3
- o_syndromes and o_ELP_search_needed hold their value from FULL until the next chunk-0 accept, so the downstream capture edge always sees stable data.
- Boundaries:
  - i_sc_valid in FULL or ISSUE is ignored; upstream must hold it, since ready=0.
  - A block of all-zero chunks is still issued, with o_ELP_search_needed=0 and o_block_clean=1.
  - Multi=1: every accept goes straight to FULL.
  - i_stop_dec during ISSUE: the current pulse completes in that cycle, then the next state is COLLECT with counter 0.

Optional Feature:
- Macro: SC_COLLECT_STATS_EN.
- With the macro defined, two extra outputs are present:
  - o_stat_blocks [15:0]: saturating count of ISSUE cycles
  - o_stat_dirty_blocks [15:0]: saturating count of issues with o_block_clean=0
- Both counters are cleared by i_RESET only; i_stop_dec does not clear them.
- Without the macro the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package d_SC_pkg holds:
  - state one-hot localparams (COLLECT/FULL/ISSUE)
  - default GF/Syndromes/Multi constants
  - a packing index function: bit offset of (syndrome s, chunk k)
- One natural sub-module, d_SC_zero_detect: a GF*Syndromes-wide OR reduction producing the nonzero flag, optionally pipelined later.

Test Plan:
- Reset with i_sc_valid=1 -> all outputs 0, o_sc_ready=1 next cycle, no accept during reset.
- Multi=2, chunk0 S1=0x001 (others 0), chunk1 all 0, i_buf_available=1 -> o_exe_buf one cycle at N+2, o_ELP_search_needed=2'b01, o_block_clean=0, o_syndromes bits[GF*Syndromes*2-1 -: 24] = 0x000_001.
- Two all-zero chunks -> o_exe_buf pulse with o_ELP_search_needed=0, o_block_clean=1.
- Block full, i_buf_available=0 for 10 cycles -> o_sc_ready=0 throughout, o_exe_buf stays 0, data stable; pulse 1 cycle after available rises.
- After accepting chunk0 (S27=0xABC), assert i_stop_dec -> counter 0; next two chunks of 0 issue with o_syndromes=0 (chunk0 data discarded).
- SC_COLLECT_STATS_EN: issue 3 blocks (1 dirty) -> o_stat_blocks=3, o_stat_dirty_blocks=1; i_stop_dec leaves them unchanged.
